pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_stage_if.sv | 42 ++++
 rtl/pipe_stage.sv | 124 ++++++++++++
 tb/tb_pipe_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_if.sv
// pipe_stage_if -- groups the stream handshake, flush and status signals of a
// pipe_stage so the stage and its environment connect through one port.
//
// Valid/ready contract (both sides): a word moves on a rising clk edge when
// valid and ready are both 1 at that edge. The sender keeps valid and data
// stable until the transfer happens; ready may change freely while valid is
// low. in_ready is a flop output and never depends on out_ready in the same
// cycle.
//
// Signals:
//   in_valid / in_ready / in_data    upstream -> stage
//   out_valid / out_ready / out_data stage -> downstream
//   flush                            discard every held word (synchronous)
//   occ                              held-word count, also the FSM state
//   stall_cnt                        saturating count of stalled output cycles
//
// Modports: master = environment (upstream source + downstream sink),
//           slave  = the stage itself.
interface pipe_stage_if #(
  parameter int DW = 16,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
  logic [CW-1:0] stall_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, occ, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, occ, stall_cnt
  );
endinterface

// File: rtl/pipe_stage.sv
// pipe_stage -- one registered pipeline stage with a skid register, so the
// upstream ready can be a flop while full throughput is still sustained.
//
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   asynchronous, active-low reset
//   bus   pipe_stage_if.slave: in_valid/in_ready/in_data, out_valid/
//         out_ready/out_data, flush, occ (FSM state), stall_cnt
//
// Storage: main_q drives out_data; skid_q catches the one word that arrives
// in the cycle the downstream stalls. Any register that holds no valid word
// is parked at NOP, so out_data reads NOP whenever out_valid is 0.
module pipe_stage #(
  parameter int            DW  = 16,
  parameter logic [DW-1:0] NOP = '0,
  parameter int            CW  = 8
) (
  input logic         clk,
  input logic         rst,
  pipe_stage_if.slave bus
);

  // State encoding equals the number of held words; it is exported as occ.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [CW-1:0] stall_q, stall_d;

  logic in_acc;
  logic out_acc;

  assign in_acc  = bus.in_valid & in_ready_q;
  assign out_acc = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      // Incoming word is dropped even if accepted; a word taken downstream
      // this cycle is simply gone, which emptying the stage already reflects.
      state_d = EMPTY;
      main_d  = NOP;
      skid_d  = NOP;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_acc) begin
            main_d  = bus.in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          case ({in_acc, out_acc})
            2'b11: main_d = bus.in_data;
            2'b10: begin
              skid_d  = bus.in_data;
              state_d = FULL;
            end
            2'b01: begin
              main_d  = NOP;
              state_d = EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          // in_ready is 0 here, so only the skid word can move forward.
          if (out_acc) begin
            main_d  = skid_q;
            skid_d  = NOP;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP;
          skid_d  = NOP;
        end
      endcase
    end
  end

  // Saturating stall counter; flush deliberately leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !bus.out_ready && (stall_q != {CW{1'b1}})) begin
      stall_d = stall_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= NOP;
      skid_q      <= NOP;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      // Handshake outputs are flopped from the next state so neither is a
      // combinational path from out_ready.
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      stall_q     <= stall_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.occ       = state_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage -- directed test of pipe_stage (DW=16, NOP=0, CW=4).
// Inputs are changed 1 time unit after a rising edge; outputs are checked at
// the same point, i.e. reflecting the state loaded by that edge.
module tb_pipe_stage;

  localparam int DW = 16;
  localparam int CW = 4;

  logic clk;
  logic rst;

  pipe_stage_if #(.DW(DW), .CW(CW)) bus ();

  pipe_stage #(
    .DW (DW),
    .NOP(16'h0000),
    .CW (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic check_state(input string tag, input logic [1:0] occ, input logic [DW-1:0] data);
    check({tag, "_occ"},   32'(bus.occ),       32'(occ));
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(occ != 2'd0));
    check({tag, "_ready"}, 32'(bus.in_ready),  32'(occ != 2'd2));
    check({tag, "_data"},  32'(bus.out_data),  32'(data));
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check_state("reset", 2'd0, 16'h0000);
    check("reset_stall", 32'(bus.stall_cnt), 32'd0);
    rst = 1'b1;

    // single word, one-cycle latency, then back to NOP
    drive(1'b1, 16'hA5A5, 1'b1, 1'b0);
    tick();
    check_state("single", 2'd1, 16'hA5A5);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check_state("single_drain", 2'd0, 16'h0000);

    // continuous streaming: one word per cycle, occ stays 1
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'(16'h1000 + i), 1'b1, 1'b0);
      exp_q.push_back(16'(16'h1000 + i));
      tick();
      check("stream_occ", 32'(bus.occ), 32'd1);
      check("stream_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end
    check("stream_stall", 32'(bus.stall_cnt), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check_state("stream_drain", 2'd0, 16'h0000);

    // back-pressure into the skid register, then drain in order
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    tick();
    check_state("bp_push1", 2'd1, 16'h0001);
    drive(1'b1, 16'h0002, 1'b0, 1'b0);
    tick();
    check_state("bp_push2", 2'd2, 16'h0001);
    drive(1'b1, 16'h0003, 1'b0, 1'b0);
    tick();
    check_state("bp_held", 2'd2, 16'h0001);
    check("bp_stall", 32'(bus.stall_cnt), 32'd2);
    drive(1'b1, 16'h0003, 1'b1, 1'b0);
    tick();
    check_state("bp_out1", 2'd1, 16'h0002);
    tick();
    check_state("bp_out2", 2'd1, 16'h0003);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check_state("bp_out3", 2'd0, 16'h0000);

    // flush from FULL with a word offered on the input
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    tick();
    check_state("fl_full", 2'd2, 16'h0011);
    drive(1'b1, 16'hFFFF, 1'b0, 1'b1);
    tick();
    check_state("flush", 2'd0, 16'h0000);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check_state("flush_after", 2'd0, 16'h0000);
    check("flush_stall_kept", 32'(bus.stall_cnt), 32'd4);

    // stall counter saturation at 15
    drive(1'b1, 16'h0033, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("stall_14", 32'(bus.stall_cnt), 32'd14);
    for (int i = 0; i < 10; i++) tick();
    check("stall_sat", 32'(bus.stall_cnt), 32'd15);
    check_state("stall_hold", 2'd1, 16'h0033);

    // asynchronous reset while FULL, observed before the next edge
    drive(1'b1, 16'h0044, 1'b0, 1'b0);
    tick();
    check_state("ar_full", 2'd2, 16'h0033);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_state("async_rst", 2'd0, 16'h0000);
    check("async_rst_stall", 32'(bus.stall_cnt), 32'd0);
    #1;
    rst = 1'b1;
    drive(1'b1, 16'h0055, 1'b1, 1'b0);
    tick();
    check_state("post_rst", 2'd1, 16'h0055);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check_state("post_rst_drain", 2'd0, 16'h0000);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
